display_log_arbiter: RTL and testbench

Sequencer that shares one formatted-display channel between `NUM_REQ` requesters. It accepts one logging item at a time under round-robin arbitration and captures its data. It then replays that item to the downstream display sink as four beats, one per radix: decimal, hex, binary, octal. It sits between datapath blocks that want to log a value and the single display/trace sink, so that log output is serialized and ordered.

---
 rtl/display_log_arbiter.sv | 114 +++++++++++
 tb/tb_display_log_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/display_log_arbiter.sv
// Round-robin sequencer sharing one display channel; each item is replayed
// as dec/hex/bin/oct beats. Define DISPLAY_LOG_ARB_PRINT_EN to self-print.
module display_log_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         data_out,
  output logic                      enable,
  output logic [1:0]                disp_radix,
  output logic [SRC_W-1:0]          disp_src,
  output logic [7:0]                disp_seq,
  input  logic                      disp_ready,
  output logic                      busy
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] sel;
  logic [SRC_W-1:0] idx;
  logic [1:0]       beat;
  logic             found;
  int               j;

  // first pending requester at or after ptr, wrapping
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = SRC_W'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && found)
      req_ready[sel] = 1'b1;
  end

  assign disp_radix = beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      beat     <= '0;
      data_out <= '0;
      enable   <= 1'b0;
      disp_src <= '0;
      disp_seq <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            data_out <= req_data[int'(sel)*DATA_W +: DATA_W];
            disp_src <= sel;
            ptr      <= (sel == SRC_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
            beat     <= '0;
            enable   <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (disp_ready) begin
            if (beat == 2'd3) begin
              beat     <= '0;
              enable   <= 1'b0;
              busy     <= 1'b0;
              disp_seq <= disp_seq + 8'd1;
              state    <= IDLE;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPLAY_LOG_ARB_PRINT_EN
  always_ff @(posedge clk) begin
    if (!rst && enable && disp_ready) begin
      unique case (disp_radix)
        2'd0: $display("src=%0d seq=%0d data=%d", disp_src, disp_seq, data_out);
        2'd1: $display("src=%0d seq=%0d data=%h", disp_src, disp_seq, data_out);
        2'd2: $display("src=%0d seq=%0d data=%b", disp_src, disp_seq, data_out);
        default: $display("src=%0d seq=%0d data=%o", disp_src, disp_seq, data_out);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_display_log_arbiter.sv
// Randomized bench for display_log_arbiter against an item-level model.
module tb_display_log_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   data_out;
  logic           enable;
  logic [1:0]     disp_radix;
  logic [1:0]     disp_src;
  logic [7:0]     disp_seq;
  logic           disp_ready;
  logic           busy;

  int vectors = 0;
  int errors  = 0;

  int m_emit, m_beat, m_ptr, m_src, m_data, m_seq;

  display_log_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .data_out(data_out),
    .enable(enable), .disp_radix(disp_radix),
    .disp_src(disp_src), .disp_seq(disp_seq),
    .disp_ready(disp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_emit = 0; m_beat = 0; m_ptr = 0;
    m_src  = 0; m_data = 0; m_seq = 0;
  endtask

  task automatic tick();
    int sel;
    int idx;
    int exp_rdy;
    #1;
    sel = -1;
    if (!m_emit && !rst)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (sel < 0 && req_valid[idx]) sel = idx;
      end
    exp_rdy = (sel >= 0) ? (1 << sel) : 0;
    chk("req_ready", 32'(req_ready), exp_rdy);
    chk("enable", 32'(enable), m_emit);
    chk("busy", 32'(busy), m_emit);
    if (m_emit != 0) chk("radix", 32'(disp_radix), m_beat);
    chk("data_out", 32'(data_out), m_data);
    chk("src", 32'(disp_src), m_src);
    chk("seq", 32'(disp_seq), m_seq);
    if (rst) begin
      model_reset();
    end else if (sel >= 0) begin
      m_emit = 1;
      m_beat = 0;
      m_src  = sel;
      m_data = int'(req_data[sel*W +: W]);
      m_ptr  = (sel + 1) % N;
    end else if (m_emit != 0 && disp_ready) begin
      if (m_beat < 3) m_beat++;
      else begin
        m_emit = 0;
        m_seq  = (m_seq + 1) % 256;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_data   = 32'h13121110;
    disp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    req_valid = '0;
    repeat (5) tick();
    // lone requester 2
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    tick();
    req_valid = '0;
    req_data  = 32'h5A5A5A5A;
    repeat (5) tick();
    // all four contending
    req_valid = '1;
    req_data  = 32'h13121110;
    repeat (25) tick();
    req_valid = '0;
    repeat (4) tick();
    // stall in beat 1
    req_valid = 4'b0001;
    req_data  = 32'h0000003C;
    tick();
    req_valid = '0;
    tick();
    disp_ready = 1'b0;
    repeat (3) tick();
    disp_ready = 1'b1;
    repeat (6) tick();
    // reset while in beat 2
    req_valid = 4'b0010;
    req_data  = 32'h00007700;
    tick();
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (6) tick();
    // 256+ items back to back to wrap the sequence counter
    req_valid = '1;
    for (int i = 0; i < 1300; i++) begin
      req_data = $urandom;
      tick();
    end
    for (int i = 0; i < 3000; i++) begin
      req_valid  = N'($urandom);
      req_data   = $urandom;
      disp_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 150) == 0;
      tick();
    end
    rst = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
